// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HALT sequencer that reads a
// combinational instruction memory into a 2-entry {word, pc} queue.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] word_q [2];
    logic [31:0] word_d [2];
    logic [31:0] epc_q [2];
    logic [31:0] epc_d [2];

    logic        pop;
    logic        slot_free;
    logic        is_halt;
    logic        fetching;
    logic        push;
    logic        flush;
    logic [31:0] target_pc;
    logic        unused_ok;

    // Target is word aligned; the dropped low bits are intentionally ignored.
    assign target_pc = {redirect_pc[31:2], 2'b00};
    assign unused_ok = ^redirect_pc[1:0];

    // Handshake and fetch qualification for the current cycle.
    always_comb begin
        pop       = instr_valid && instr_ready;
        slot_free = (count_q != 2'd2) || pop;
        is_halt   = (imem_data == HALT_WORD);
        fetching  = (state_q == S_FETCH) && !redirect && slot_free;
        push      = fetching && !is_halt;
        flush     = redirect && (state_q != S_IDLE);
    end

    // Sequencer: redirect outranks both run and the halt detection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!redirect && run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!redirect && fetching && is_halt) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // PC: load on redirect, step by one word on every accepted fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target_pc;
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Queue bookkeeping; a flush drops both entries and any pop this cycle.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        word_d   = word_q;
        epc_d    = epc_q;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q] = imem_data;
                epc_d[wr_ptr_q]  = pc_q;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            word_q[0] <= 32'd0;
            word_q[1] <= 32'd0;
            epc_q[0]  <= 32'd0;
            epc_q[1]  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            word_q[0] <= word_d[0];
            word_q[1] <= word_d[1];
            epc_q[0]  <= epc_d[0];
            epc_q[1]  <= epc_d[1];
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = word_q[rd_ptr_q];
    assign instr_pc    = epc_q[rd_ptr_q];
    assign instr_valid = (count_q != 2'd0);
    assign halted      = (state_q == S_HALT) && (count_q == 2'd0);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random
// traffic, compared against a queue-based model of the fetch rules.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halted;

    logic [31:0] rom_mem [64];

    int n_chk  = 0;
    int n_pass = 0;

    typedef enum int {M_IDLE, M_FETCH, M_HALT} mstate_t;
    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    mstate_t     mst = M_IDLE;
    logic [31:0] mpc = RESET_PC;

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign imem_data = rom_mem[imem_addr[7:2]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one step of the fetch rules per clock edge.
    task automatic model_reset();
        mq.delete();
        mst = M_IDLE;
        mpc = RESET_PC;
    endtask

    task automatic model_step();
        logic [31:0] w;
        bit          pop;
        pop = (mq.size() != 0) && instr_ready;
        if (redirect) begin
            mpc = {redirect_pc[31:2], 2'b00};
            if (mst != M_IDLE) begin
                mq.delete();
                mst = M_FETCH;
            end else if (pop) begin
                void'(mq.pop_front());
            end
            return;
        end
        if (pop) void'(mq.pop_front());
        case (mst)
            M_IDLE: if (run) mst = M_FETCH;
            M_FETCH: begin
                if (mq.size() < 2) begin
                    w = rom_mem[mpc[7:2]];
                    if (w == HALT_WORD) begin
                        mst = M_HALT;
                    end else begin
                        mq.push_back('{w, mpc});
                        mpc = mpc + 32'd4;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Monitor: compare what the DUT presents against the model queue head.
    task automatic monitor();
        chk("imem_addr", imem_addr, mpc);
        chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
        chk("halted", 32'(halted), 32'(mst == M_HALT && mq.size() == 0));
        if (instr_valid && mq.size() != 0) begin
            chk("sb_instr", instr, mq[0].w);
            chk("sb_instr_pc", instr_pc, mq[0].pc);
        end
    endtask

    always @(negedge clk) monitor();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h1000_0000 + i;
        rom_mem[0]  = 32'hE3A0_1005;
        rom_mem[1]  = 32'hE281_1001;
        rom_mem[2]  = 32'h0000_0000;
        rom_mem[8]  = 32'hAAAA_0008;
        rom_mem[9]  = 32'hAAAA_0009;
        rom_mem[10] = 32'h0000_0000;
    endtask

    initial begin
        logic [31:0] w;
        load_prog();
        do_reset();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", imem_addr, RESET_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);

        // Straight-line program ending in a halt word.
        instr_ready = 1'b1;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("p_valid0", 32'(instr_valid), 32'd1);
        chk("p_instr0", instr, 32'hE3A0_1005);
        chk("p_pc0", instr_pc, 32'd0);
        step();
        chk("p_instr1", instr, 32'hE281_1001);
        chk("p_pc1", instr_pc, 32'd4);
        step();
        chk("p_halted", 32'(halted), 32'd1);
        chk("p_halt_pc", imem_addr, 32'd8);

        // Backpressure: queue fills and head holds.
        do_reset();
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr", instr, 32'hE3A0_1005);
            chk("bp_pc", instr_pc, 32'd0);
            step();
        end
        chk("bp_full_pc", imem_addr, 32'd8);

        // Redirect with two entries queued.
        redirect = 1'b1;
        redirect_pc = 32'h22;
        step();
        redirect = 1'b0;
        chk("rd_valid", 32'(instr_valid), 32'd0);
        chk("rd_pc", imem_addr, 32'h20);
        step();
        chk("rd_first_pc", instr_pc, 32'h20);

        // Drain to halt, then restart via redirect.
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !halted; i++) step();
        chk("hr_halted", 32'(halted), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'd0;
        step();
        redirect = 1'b0;
        chk("hr_unhalt", 32'(halted), 32'd0);
        step();
        chk("hr_valid", 32'(instr_valid), 32'd1);
        chk("hr_pc", instr_pc, 32'd0);

        // PC wrap from the top of the address space.
        do_reset();
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h5000_0000 + i;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wr_idle_pc", imem_addr, 32'hFFFF_FFFC);
        chk("wr_idle_valid", 32'(instr_valid), 32'd0);
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("wr_pc0", instr_pc, 32'hFFFF_FFFC);
        step();
        chk("wr_pc1", instr_pc, 32'h0000_0000);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if ($urandom % 12 == 0) w = HALT_WORD;
            else if (w == HALT_WORD) w = 32'h1;
            rom_mem[i] = w;
        end
        run = 1'b1;
        step();
        for (int c = 0; c < 1500; c++) begin
            run = 1'($urandom % 10 == 0);
            instr_ready = 1'($urandom % 10 < 7);
            redirect = 1'($urandom % 25 == 0) ||
                       (halted && ($urandom % 3 == 0));
            if ($urandom % 8 == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom % 16);
            else redirect_pc = $urandom_range(0, 255);
            step();
        end

        // Asynchronous reset between clock edges.
        rom_mem[0] = 32'hCAFE_0000;
        rom_mem[1] = 32'hCAFE_0004;
        redirect = 1'b1;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        step();
        redirect = 1'b0;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_halted", 32'(halted), 32'd0);
        chk("ar_instr", instr, 32'd0);
        chk("ar_instr_pc", instr_pc, 32'd0);
        chk("ar_pc", imem_addr, RESET_PC);
        step();
        reset_n = 1'b1;
        run = 1'b0;
        instr_ready = 1'b1;
        step();
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        chk("ar_first_valid", 32'(instr_valid), 32'd1);
        chk("ar_first_pc", instr_pc, RESET_PC);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'h0000_0000, meaning the fetched word that marks end of program.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1 bit: start fetching from IDLE.
REQ-006 SHALL have port imem_addr, output, 32 bits: word address to the combinational instruction memory; equals PC.
REQ-007 SHALL have port imem_data, input, 32 bits: memory word for imem_addr, valid in the same cycle.
REQ-008 SHALL have port instr, output, 32 bits: instruction word at the queue head.
REQ-009 SHALL have port instr_pc, output, 32 bits: address of instr.
REQ-010 SHALL have port instr_valid, output, 1 bit: queue head is valid.
REQ-011 SHALL have port instr_ready, input, 1 bit: consumer accepts the head this cycle.
REQ-012 SHALL have port redirect, input, 1 bit: one-cycle branch/redirect request.
REQ-013 SHALL have port redirect_pc, input, 32 bits: redirect target address.
REQ-014 SHALL have port halted, output, 1 bit: program finished and queue drained.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH and HALT.
REQ-016 SHALL go IDLE->FETCH on run=1; FETCH->HALT when imem_data==HALT_WORD while a push would occur; HALT->FETCH only on redirect; IDLE stays IDLE on redirect.
REQ-017 SHALL contain a 2-entry FIFO of {word, pc}; instr_valid = (count!=0); instr/instr_pc driven from the head entry.
REQ-018 SHALL pop one entry when instr_valid && instr_ready are both high.
REQ-019 SHALL push {imem_data, PC} and advance PC by 4 in FETCH when (count<2 || pop) && imem_data!=HALT_WORD && !redirect.
REQ-020 SHALL, on a HALT_WORD fetch, neither push nor advance PC; PC keeps the HALT_WORD address.
REQ-021 SHALL, on simultaneous push and pop, keep count unchanged with correct FIFO ordering.
REQ-022 SHALL hold instr and instr_pc stable while instr_valid && !instr_ready.
REQ-023 SHALL, on redirect in FETCH or HALT, take priority over push: flush the FIFO (count=0 next cycle, any pop that cycle is discarded), load PC={redirect_pc[31:2],2'b00}, and enter FETCH.
REQ-024 SHALL, on redirect in IDLE, load PC with the aligned target and leave the FIFO unchanged.
REQ-025 SHALL wrap PC from 32'hFFFF_FFFC to 32'h0000_0000 (modulo-2^32 add).
REQ-026 SHALL drive halted=1 exactly when state==HALT && count==0.
REQ-027 SHALL start fetching one cycle after run is sampled, with a first-fetch-to-instr_valid latency of 1 cycle.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously set state=IDLE, PC=RESET_PC, count=0, FIFO pointers=0, instr_valid=0, halted=0, and instr/instr_pc=0.
REQ-029 SHALL, when reset is asserted mid-operation, discard all queued entries; the first fetch after release comes from RESET_PC.

Verification
REQ-030 SHALL pass this scenario: ROM at 0/4/8 = E3A01005/E2811001/00000000, run pulse, ready=1 -> instr E3A01005@0 then E2811001@4 on consecutive cycles, then halted=1 with PC=8.
REQ-031 SHALL pass this scenario: ready=0 for 5 cycles after start -> count saturates at 2, PC=8, and instr holds E3A01005@0 for all 5 cycles.
REQ-032 SHALL pass this scenario: redirect=1 with redirect_pc=0x22 while 2 entries are queued -> next cycle instr_valid=0, PC=0x20, and the following instr_pc=0x20.
REQ-033 SHALL pass this scenario: redirect in HALT with target 0 -> FETCH resumes, halted drops, and instr_pc=0 is reissued.
REQ-034 SHALL pass this scenario: PC preloaded via IDLE redirect to 0xFFFFFFFC, non-halt ROM -> instr_pc sequence FFFFFFFC, 00000000.
REQ-035 SHALL pass this scenario: reset_n pulsed low mid-stream, asynchronous to clk -> outputs are 0 immediately, and after release the first instr_pc=RESET_PC.
